riscv_memory_lsu: RTL and testbench

Parametrised memory-stage load/store unit that supersedes the plain data-memory stage. It owns a word-organised data RAM of configurable depth and decodes RV32I funct3 for byte, halfword and word access. It performs lane alignment on stores and sign or zero extension on loads. Loads have a configurable multi-cycle latency with a busy/valid handshake toward the pipeline hazard logic.

---
 rtl/riscv_memory_lsu.sv | 187 ++++++++++++++++++
 tb/tb_riscv_memory_lsu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_memory_lsu
// Purpose  : RV32I memory-stage load/store unit with private word RAM,
//            lane-aligned stores and extended multi-cycle loads.
//            Optional misaligned-access trap: RISCV_LSU_MISALIGN_TRAP_EN
// Revision : 1.0  initial release
// ============================================================================
module riscv_memory_lsu #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_busy,
    output logic        o_misalign
);

    localparam int         c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [2:0] c_CNT_INIT = 3'(LATENCY - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    logic [31:0]           r_mem [0:c_DEPTH-1];

    logic [1:0]            r_state_q, w_state_d;
    logic [2:0]            r_cnt_q,   w_cnt_d;
    logic [DEPTH_LOG2-1:0] r_idx_q,   w_idx_d;
    logic [1:0]            r_off_q,   w_off_d;
    logic [2:0]            r_f3_q,    w_f3_d;
    logic [31:0]           r_rdata_q, w_rdata_d;
    logic                  r_mis_q,   w_mis_d;

    logic                  w_busy, w_rvalid;
    logic                  w_accept, w_load_start, w_misaligned;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata_rep;
    logic [31:0]           w_word, w_load_val;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic                  w_unused_addr;

    // Upper address bits only alias the RAM.
    assign w_idx         = i_addr[DEPTH_LOG2+1:2];
    assign w_unused_addr = ^i_addr[31:DEPTH_LOG2+2];

    assign w_accept     = i_req && !w_busy;
    assign w_load_start = w_accept && !i_we && !w_misaligned;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    always_comb begin
        w_misaligned = 1'b0;
        case (i_funct3)
            c_F3_H:  w_misaligned = i_addr[0];
            c_F3_HU: w_misaligned = !i_we && i_addr[0];
            c_F3_W:  w_misaligned = |i_addr[1:0];
            default: w_misaligned = 1'b0;
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_mis_d = w_accept && w_misaligned;

    // Store lane enables and replicated write data.
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = i_wdata;
        if (w_accept && i_we && !w_misaligned) begin
            case (i_funct3)
                c_F3_B: begin
                    w_be        = 4'b0001 << i_addr[1:0];
                    w_wdata_rep = {4{i_wdata[7:0]}};
                end
                c_F3_H: begin
                    w_be        = i_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata_rep = {2{i_wdata[15:0]}};
                end
                c_F3_W:  w_be = 4'b1111;
                default: w_be = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
            end
        end
    end

    // Load extraction from the captured word index and lane.
    assign w_word = r_mem[r_idx_q];
    assign w_byte = w_word[8*r_off_q +: 8];
    assign w_half = r_off_q[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_val = 32'h0;
        case (r_f3_q)
            c_F3_B:  w_load_val = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_load_val = {{16{w_half[15]}}, w_half};
            c_F3_W:  w_load_val = w_word;
            c_F3_BU: w_load_val = {24'h0, w_byte};
            c_F3_HU: w_load_val = {16'h0, w_half};
            default: w_load_val = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state_q <= c_S_IDLE;
            r_cnt_q   <= 3'd0;
            r_idx_q   <= '0;
            r_off_q   <= 2'd0;
            r_f3_q    <= 3'd0;
            r_rdata_q <= 32'h0;
            r_mis_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_idx_q   <= w_idx_d;
            r_off_q   <= w_off_d;
            r_f3_q    <= w_f3_d;
            r_rdata_q <= w_rdata_d;
            r_mis_q   <= w_mis_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_idx_d   = r_idx_q;
        w_off_d   = r_off_q;
        w_f3_d    = r_f3_q;
        w_rdata_d = r_rdata_q;
        case (r_state_q)
            c_S_IDLE, c_S_RESP: begin
                w_state_d = w_load_start ? c_S_WAIT : c_S_IDLE;
            end
            c_S_WAIT: begin
                if (r_cnt_q == 3'd0) begin
                    w_rdata_d = w_load_val;
                    w_state_d = c_S_RESP;
                end else begin
                    w_cnt_d = r_cnt_q - 3'd1;
                end
            end
            default: w_state_d = c_S_IDLE;
        endcase
        if (w_load_start) begin
            w_idx_d = w_idx;
            w_off_d = i_addr[1:0];
            w_f3_d  = i_funct3;
            w_cnt_d = c_CNT_INIT;
        end
    end

    always_comb begin
        w_busy   = (r_state_q == c_S_WAIT);
        w_rvalid = (r_state_q == c_S_RESP);
    end

    assign o_busy     = w_busy;
    assign o_rvalid   = w_rvalid;
    assign o_rdata    = r_rdata_q;
    assign o_misalign = r_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_memory_lsu
// Purpose  : Directed self-checking bench for riscv_memory_lsu, LATENCY 1 and 4
// Revision : 1.0  initial release
// ============================================================================
module tb_riscv_memory_lsu;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    localparam bit c_TRAP = 1'b1;
`else
    localparam bit c_TRAP = 1'b0;
`endif

    logic        r_clk = 1'b0;
    logic        r_rstn, r_req, r_we, r_sel;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;

    logic [31:0] w_rdata1, w_rdata4, w_rdata;
    logic        w_rvalid1, w_rvalid4, w_rvalid;
    logic        w_busy1, w_busy4, w_busy;
    logic        w_mis1, w_mis4, w_mis;

    int n_cmp = 0;
    int n_err = 0;

    always #5 r_clk = ~r_clk;

    riscv_memory_lsu #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut (
        .i_clk(r_clk), .i_rstn(r_rstn), .i_req(r_req & ~r_sel), .i_we(r_we),
        .i_funct3(r_f3), .i_addr(r_addr), .i_wdata(r_wdata),
        .o_rdata(w_rdata1), .o_rvalid(w_rvalid1), .o_busy(w_busy1), .o_misalign(w_mis1)
    );

    riscv_memory_lsu #(.DEPTH_LOG2(10), .LATENCY(4)) u_dut_l4 (
        .i_clk(r_clk), .i_rstn(r_rstn), .i_req(r_req & r_sel), .i_we(r_we),
        .i_funct3(r_f3), .i_addr(r_addr), .i_wdata(r_wdata),
        .o_rdata(w_rdata4), .o_rvalid(w_rvalid4), .o_busy(w_busy4), .o_misalign(w_mis4)
    );

    assign w_rdata  = r_sel ? w_rdata4  : w_rdata1;
    assign w_rvalid = r_sel ? w_rvalid4 : w_rvalid1;
    assign w_busy   = r_sel ? w_busy4   : w_busy1;
    assign w_mis    = r_sel ? w_mis4    : w_mis1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input bit exp_mis);
        @(negedge r_clk);
        r_req = 1'b1; r_we = 1'b1; r_f3 = f3; r_addr = a; r_wdata = d;
        @(negedge r_clk);
        r_req = 1'b0; r_we = 1'b0;
        check({tag, ".mis"},  32'(w_mis),  32'(exp_mis));
        check({tag, ".busy"}, 32'(w_busy), 32'h0);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp, input bit exp_trap);
        int          lat   = r_sel ? 4 : 1;
        int          lim   = exp_trap ? 4 : 20;
        int          nbusy = 0;
        bit          seen  = 1'b0;
        logic        mis0;
        logic [31:0] got   = 32'h0;
        @(negedge r_clk);
        r_req = 1'b1; r_we = 1'b0; r_f3 = f3; r_addr = a;
        @(negedge r_clk);
        r_req = 1'b0;
        mis0  = w_mis;
        for (int i = 0; i < lim && !seen; i++) begin
            if (w_busy) nbusy++;
            if (w_rvalid) begin
                seen = 1'b1;
                got  = w_rdata;
            end else begin
                @(negedge r_clk);
            end
        end
        check({tag, ".mis"},    32'(mis0),  32'(exp_trap));
        check({tag, ".busy"},   32'(nbusy), exp_trap ? 32'd0 : 32'(lat));
        check({tag, ".rvalid"}, 32'(seen),  32'(!exp_trap));
        if (seen) check({tag, ".data"}, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          nbusy;
        int          nrv;
        logic [31:0] got;

        r_rstn = 1'b0; r_req = 1'b0; r_we = 1'b0; r_sel = 1'b0;
        r_f3 = 3'd0; r_addr = 32'h0; r_wdata = 32'h0;
        repeat (3) @(negedge r_clk);
        check("rst.rdata",  w_rdata,        32'h0);
        check("rst.rvalid", 32'(w_rvalid),  32'h0);
        check("rst.busy",   32'(w_busy),    32'h0);
        check("rst.mis",    32'(w_mis),     32'h0);
        check("rst.busy4",  32'(w_busy4),   32'h0);
        r_rstn = 1'b1;

        // LATENCY = 1 instance
        do_store("sw10", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        do_load ("lw10", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        do_store("sb13", 3'b000, 32'h13, 32'h12345680, 1'b0);
        do_load ("lb13",  3'b000, 32'h13, 32'hFFFFFF80, 1'b0);
        do_load ("lbu13", 3'b100, 32'h13, 32'h00000080, 1'b0);
        do_load ("lw10b", 3'b010, 32'h10, 32'h80ADBEEF, 1'b0);
        do_load ("alias", 3'b010, 32'h8000_1010, 32'h80ADBEEF, 1'b0);

        do_store("sw20", 3'b010, 32'h20, 32'h00000000, 1'b0);
        do_store("sh22", 3'b001, 32'h22, 32'hABCD8001, 1'b0);
        do_load ("lh22",  3'b001, 32'h22, 32'hFFFF8001, 1'b0);
        do_load ("lhu22", 3'b101, 32'h22, 32'h00008001, 1'b0);
        do_load ("lw20",  3'b010, 32'h20, 32'h80010000, 1'b0);
        do_load ("lb22",  3'b000, 32'h22, 32'h00000001, 1'b0);
        do_load ("lbu23", 3'b100, 32'h23, 32'h00000080, 1'b0);

        do_load ("ldill", 3'b011, 32'h10, 32'h00000000, 1'b0);
        do_store("still", 3'b011, 32'h10, 32'h12345678, 1'b0);
        do_load ("lw10c", 3'b010, 32'h10, 32'h80ADBEEF, 1'b0);

        // Misaligned accesses: trapped, or forced to natural alignment
        do_store("sw30", 3'b010, 32'h30, 32'hCAFEF00D, 1'b0);
        do_store("sw31", 3'b010, 32'h31, 32'h11223344, c_TRAP);
        do_load ("lw30", 3'b010, 32'h30, c_TRAP ? 32'hCAFEF00D : 32'h11223344, 1'b0);
        do_load ("lb31", 3'b000, 32'h31, c_TRAP ? 32'hFFFFFFF0 : 32'h00000033, 1'b0);
        do_load ("lw32", 3'b010, 32'h32, c_TRAP ? 32'hCAFEF00D : 32'h11223344, c_TRAP);
        do_load ("lh23", 3'b001, 32'h23, 32'hFFFF8001, c_TRAP);
        do_load ("lw02", 3'b010, 32'h02, 32'h0, c_TRAP);

        // LATENCY = 4 instance
        r_sel = 1'b1;
        do_store("sw10_l4", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);

        // Request held high across the whole load and past RESP
        @(negedge r_clk);
        r_req = 1'b1; r_we = 1'b0; r_f3 = 3'b010; r_addr = 32'h10;
        nbusy = 0; nrv = 0; got = 32'h0;
        for (int i = 0; i < 20 && nrv == 0; i++) begin
            @(negedge r_clk);
            if (w_busy) nbusy++;
            if (w_rvalid) begin
                nrv++;
                got = w_rdata;
            end
        end
        check("held.busy",   32'(nbusy), 32'd4);
        check("held.rvalid", 32'(nrv),   32'd1);
        check("held.data",   got,        32'hDEADBEEF);
        @(negedge r_clk);
        check("held.reacc_busy",   32'(w_busy),   32'h1);
        check("held.reacc_rvalid", 32'(w_rvalid), 32'h0);
        r_req = 1'b0;
        nbusy = 1; nrv = 0;
        for (int i = 0; i < 20 && nrv == 0; i++) begin
            @(negedge r_clk);
            if (w_busy) nbusy++;
            if (w_rvalid) nrv++;
        end
        check("held2.busy",   32'(nbusy), 32'd4);
        check("held2.rvalid", 32'(nrv),   32'd1);

        // Reset asserted while the load is waiting
        @(negedge r_clk);
        r_req = 1'b1; r_we = 1'b0; r_f3 = 3'b010; r_addr = 32'h10;
        @(negedge r_clk);
        r_req = 1'b0;
        @(negedge r_clk);
        check("midrst.pre_busy", 32'(w_busy), 32'h1);
        r_rstn = 1'b0;
        #1;
        check("midrst.busy",   32'(w_busy),   32'h0);
        check("midrst.rvalid", 32'(w_rvalid), 32'h0);
        check("midrst.rdata",  w_rdata,       32'h0);
        repeat (2) @(negedge r_clk);
        r_rstn = 1'b1;
        nrv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge r_clk);
            if (w_rvalid) nrv++;
        end
        check("midrst.no_cpl", 32'(nrv), 32'd0);
        do_load("lw10_l4", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
